// File: rtl/pwm_blk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_blk_gen
//  Purpose  : PWM / blanking generator with shadowed config and a divided
//             block clock. Config is reloaded only at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_blk_gen #(
    parameter int C_DUTY_WIDTH = 8,
    parameter int C_PCNT_WIDTH = 16
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    enable,
    input  logic [31:0]             pwm_clk_div,
    input  logic [31:0]             pwm_blk_duty_cycle,
    output logic                    pwm_out,
    output logic                    pwm_blk_clk_out,
    output logic                    period_start,
    output logic                    running,
    output logic [C_PCNT_WIDTH-1:0] period_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    localparam logic [C_DUTY_WIDTH-1:0] c_phase_max = '1;
    localparam logic [C_DUTY_WIDTH:0]   c_duty_full = {1'b1, {C_DUTY_WIDTH{1'b0}}};

    logic [1:0]              r_state;
    logic [31:0]             r_div_sh;
    logic [C_DUTY_WIDTH:0]   r_duty_sh;
    logic [31:0]             r_div_cnt;
    logic [C_DUTY_WIDTH-1:0] r_phase;
    logic                    r_blk_clk;
    logic                    r_period_start;
    logic [C_PCNT_WIDTH-1:0] r_period_count;

    logic                    w_running;
    logic                    w_tick;
    logic                    w_wrap;
    logic [C_DUTY_WIDTH:0]   w_duty_clamp;

    // Duty values at or above the period length all mean 100 %.
    assign w_duty_clamp = (pwm_blk_duty_cycle >= 32'(c_duty_full)) ? c_duty_full
                                                                    : pwm_blk_duty_cycle[C_DUTY_WIDTH:0];

    assign w_running = (r_state == c_st_run);
    assign w_tick    = w_running && (r_div_cnt == r_div_sh);
    assign w_wrap    = w_tick && (r_phase == c_phase_max);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state        <= c_st_idle;
            r_div_sh       <= '0;
            r_duty_sh      <= '0;
            r_div_cnt      <= '0;
            r_phase        <= '0;
            r_blk_clk      <= 1'b0;
            r_period_start <= 1'b0;
            r_period_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_blk_clk      <= 1'b0;
                    r_period_start <= 1'b0;
                    if (enable) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_div_sh       <= pwm_clk_div;
                    r_duty_sh      <= w_duty_clamp;
                    r_div_cnt      <= '0;
                    r_phase        <= '0;
                    r_blk_clk      <= 1'b0;
                    r_period_start <= 1'b1;
                    r_state        <= c_st_run;
                end
                c_st_run: begin
                    r_period_start <= 1'b0;
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_phase   <= r_phase + 1'b1;
                        r_blk_clk <= ~r_blk_clk;
                        if (w_wrap) begin
                            r_period_count <= r_period_count + 1'b1;
                            // Reload in place keeps the block clock phase running across the wrap.
                            if (enable) begin
                                r_div_sh       <= pwm_clk_div;
                                r_duty_sh      <= w_duty_clamp;
                                r_period_start <= 1'b1;
                            end else begin
                                r_blk_clk <= 1'b0;
                                r_state   <= c_st_idle;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign running         = w_running;
    assign pwm_out         = w_running && ({1'b0, r_phase} < r_duty_sh);
    assign pwm_blk_clk_out = r_blk_clk;
    assign period_start    = r_period_start;
    assign period_count    = r_period_count;

endmodule
`default_nettype wire

// File: tb/tb_pwm_blk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_blk_gen
//  Purpose  : Directed, scoreboard-based bench for pwm_blk_gen (16-step period).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_blk_gen;

    localparam int C_DUTY_WIDTH = 4;
    localparam int C_PCNT_WIDTH = 3;
    localparam int c_steps      = 1 << C_DUTY_WIDTH;
    localparam int c_pc_mod     = 1 << C_PCNT_WIDTH;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [31:0]             div;
    logic [31:0]             duty;
    logic                    pwm_out;
    logic                    blk_clk;
    logic                    period_start;
    logic                    running;
    logic [C_PCNT_WIDTH-1:0] period_count;

    typedef struct packed {
        logic        pwm;
        logic        blk;
        logic        ps;
        logic        run;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    pwm_blk_gen #(
        .C_DUTY_WIDTH (C_DUTY_WIDTH),
        .C_PCNT_WIDTH (C_PCNT_WIDTH)
    ) u_dut (
        .S_AXI_ACLK         (clk),
        .S_AXI_ARESETN      (rst_n),
        .enable             (enable),
        .pwm_clk_div        (div),
        .pwm_blk_duty_cycle (duty),
        .pwm_out            (pwm_out),
        .pwm_blk_clk_out    (blk_clk),
        .period_start       (period_start),
        .running            (running),
        .period_count       (period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".pwm_out"},      32'(pwm_out),      32'(e.pwm));
        chk({tag, ".blk_clk"},      32'(blk_clk),      32'(e.blk));
        chk({tag, ".period_start"}, 32'(period_start), 32'(e.ps));
        chk({tag, ".running"},      32'(running),      32'(e.run));
        chk({tag, ".period_count"}, 32'(period_count), e.pc);
    endtask

    // One full period's worth of per-cycle expectations for a given config.
    task automatic push_period(input int d, input logic [31:0] u, input int pc);
        int   uc;
        int   step;
        exp_t e;
        uc = (u >= 32'(c_steps)) ? c_steps : int'(u);
        for (int n = 0; n < c_steps * (d + 1); n++) begin
            step  = n / (d + 1);
            e.pwm = (step < uc);
            e.blk = step[0];
            e.ps  = (n == 0);
            e.run = 1'b1;
            e.pc  = 32'(pc % c_pc_mod);
            q.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk_all("run", e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag, input int pc);
        exp_t e;
        e = '{pwm: 1'b0, blk: 1'b0, ps: 1'b0, run: 1'b0, pc: 32'(pc % c_pc_mod)};
        chk_all(tag, e);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        div    = 32'd0;
        duty   = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset", 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("idle_after_reset", 0);

        // Basic run: div=0, duty=4
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("load_cycle", 0);
        @(posedge clk);
        #1;
        push_period(0, 32'd4, 0);
        push_period(0, 32'd4, 1);
        drain(32);

        // Duty change mid-period takes effect only after the wrap
        push_period(0, 32'd4, 2);
        drain(6);
        duty = 32'd12;
        push_period(0, 32'd12, 3);
        drain(26);

        // Divider change mid-period likewise
        push_period(0, 32'd12, 4);
        drain(6);
        div = 32'd1;
        push_period(1, 32'd12, 5);
        drain(42);

        // Duty extremes: 0, exactly full, and saturating
        push_period(1, 32'd12, 6);
        duty = 32'd0;
        div  = 32'd0;
        drain(32);
        push_period(0, 32'd0, 7);
        duty = 32'd16;
        drain(16);
        push_period(0, 32'd16, 8);
        duty = 32'hFFFF_FFFF;
        drain(16);

        // Enable dropped then re-raised before the wrap: no stop
        push_period(0, 32'hFFFF_FFFF, 9);
        duty = 32'd4;
        drain(3);
        enable = 1'b0;
        drain(5);
        enable = 1'b1;
        drain(8);

        // Enable dropped at phase 5: finish the period, then IDLE
        push_period(0, 32'd4, 10);
        drain(5);
        enable = 1'b0;
        drain(11);
        chk_idle("stopped", 11);
        repeat (4) @(posedge clk);
        #1;
        chk_idle("idle_hold", 11);

        // Fresh start with div=2, duty=8
        div    = 32'd2;
        duty   = 32'd8;
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("load2", 11);
        @(posedge clk);
        #1;
        push_period(2, 32'd8, 11);
        push_period(2, 32'd8, 12);
        drain(96);

        // Asynchronous reset mid-period
        push_period(2, 32'd8, 13);
        drain(20);
        q.delete();
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset", 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("load_after_reset", 0);
        @(posedge clk);
        #1;
        push_period(2, 32'd8, 0);
        drain(48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
